nv_nvdla_sdp_ro_cfifo_gen: RTL and testbench

Parametrised flop-RAM FIFO for the SDP NRDMA egress reorder path. It is the generic successor to the fixed 4x4 cfifo, with configurable width and depth and an optional registered output stage. It adds an occupancy count, a programmable almost-full flag, synchronous flush, and a clock-enable request for the external clock gate. It sits between the egress reorder logic and its downstream consumer, buffering per-request context.

---
 rtl/nv_nvdla_sdp_ro_cfifo_pkg.sv | 20 ++
 rtl/nv_nvdla_sdp_ro_cfifo_flopram.sv | 30 +++
 rtl/nv_nvdla_sdp_ro_cfifo_gen.sv | 134 +++++++++++++
 tb/tb_nv_nvdla_sdp_ro_cfifo_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_sdp_ro_cfifo_pkg.sv
// Shared sizing helpers and configuration checks for the SDP reorder-path context FIFO.
package nv_nvdla_sdp_ro_cfifo_pkg;

  localparam int MIN_DEPTH = 2;
  localparam int MIN_WIDTH = 1;

  // Count width must cover DEPTH+1 (RAM plus optional output register).
  function automatic int cw_f(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic bit is_pow2_f(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok_f(input int width, input int depth);
    return (width >= MIN_WIDTH) && (depth >= MIN_DEPTH) && is_pow2_f(depth);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_ro_cfifo_flopram.sv
// DEPTH x WIDTH flop array: synchronous write, asynchronous read, no reset on storage.
module nv_nvdla_sdp_ro_cfifo_flopram
  import nv_nvdla_sdp_ro_cfifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [AW-1:0]    ra_i,
  output logic [WIDTH-1:0] rd_o,
  input  logic [31:0]      pwrbus_ram_pd_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pwrbus_unused;

  // Power control is carried for the hard-macro swap; the flop model ignores it.
  assign pwrbus_unused = ^pwrbus_ram_pd_i;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/nv_nvdla_sdp_ro_cfifo_gen.sv
// Flop-RAM context FIFO: 1-cycle write-to-read (2 with RD_REG), wr_prdy low while RAM full or flushing.
// Optional output register adds one entry of capacity; flush discards same-cycle push/pop.
module nv_nvdla_sdp_ro_cfifo_gen
  import nv_nvdla_sdp_ro_cfifo_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int RD_REG = 0,
  localparam int CW    = cw_f(DEPTH)
) (
  input  logic             nvdla_core_clk_mgated,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  input  logic             flush,
  input  logic [CW-1:0]    afull_thresh,
  output logic             afull,
  output logic [CW-1:0]    occ,
  output logic             clk_en_req,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (!cfg_ok_f(WIDTH, DEPTH)) begin : g_bad_cfg
    $error("nv_nvdla_sdp_ro_cfifo_gen: DEPTH must be a power of two >= 2 and WIDTH >= 1");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
  logic             ram_full_q, ram_full_d;
  logic             push, pop, ram_rd, ram_nempty, out_vld;
  logic [WIDTH-1:0] ram_rd_pd;

  assign ram_nempty = (ram_cnt_q != '0);
  assign wr_prdy    = !ram_full_q && !flush;
  assign push       = wr_pvld && wr_prdy;
  assign pop        = rd_pvld && rd_prdy;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    ram_full_d = ram_full_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      ram_full_d = 1'b0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (ram_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(ram_rd);
      ram_full_d = (ram_cnt_d == DEPTH_C);
    end
  end

  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      ram_full_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      ram_full_q <= ram_full_d;
    end
  end

  nv_nvdla_sdp_ro_cfifo_flopram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i           (nvdla_core_clk_mgated),
    .we_i            (push),
    .wa_i            (wr_ptr_q),
    .wd_i            (wr_pd),
    .ra_i            (rd_ptr_q),
    .rd_o            (ram_rd_pd),
    .pwrbus_ram_pd_i (pwrbus_ram_pd)
  );

  if (RD_REG != 0) begin : g_rd_reg
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_pd_q, out_pd_d;

    // Refill whenever the register is empty or being drained this cycle.
    assign ram_rd = ram_nempty && (!out_vld_q || pop);

    always_comb begin
      out_vld_d = out_vld_q;
      out_pd_d  = out_pd_q;
      if (flush) begin
        out_vld_d = 1'b0;
      end else if (ram_rd) begin
        out_vld_d = 1'b1;
        out_pd_d  = ram_rd_pd;
      end else if (pop) begin
        out_vld_d = 1'b0;
      end
    end

    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
        out_vld_q <= 1'b0;
        out_pd_q  <= '0;
      end else begin
        out_vld_q <= out_vld_d;
        out_pd_q  <= out_pd_d;
      end
    end

    assign out_vld = out_vld_q;
    assign rd_pvld = out_vld_q;
    assign rd_pd   = out_pd_q;
  end else begin : g_rd_ram
    assign ram_rd  = pop;
    assign out_vld = 1'b0;
    assign rd_pvld = ram_nempty;
    assign rd_pd   = ram_rd_pd;
  end

  assign occ        = ram_cnt_q + CW'(out_vld);
  assign afull      = (occ >= afull_thresh);
  assign clk_en_req = wr_pvld || rd_pvld || flush || ram_nempty;

endmodule

// File: tb/tb_nv_nvdla_sdp_ro_cfifo_gen.sv
// Bench: RD_REG=0 and RD_REG=1 instances checked every cycle against queue-based reference models.
module tb_nv_nvdla_sdp_ro_cfifo_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wv0, rr0, fl0, wv1, rr1, fl1;
  logic [3:0] wd0, wd1;
  logic [2:0] thr;
  logic [31:0] pwr;

  logic       wr_prdy0, rd_pvld0, afull0, cer0;
  logic       wr_prdy1, rd_pvld1, afull1, cer1;
  logic [3:0] rd_pd0, rd_pd1;
  logic [2:0] occ0, occ1;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: queue of entries held; vis1 says the head sits in the output register.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  bit         vis1 = 1'b0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_ro_cfifo_gen #(.WIDTH(4), .DEPTH(4), .RD_REG(0)) u_dut0 (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .wr_pvld               (wv0),
    .wr_prdy               (wr_prdy0),
    .wr_pd                 (wd0),
    .rd_pvld               (rd_pvld0),
    .rd_prdy               (rr0),
    .rd_pd                 (rd_pd0),
    .flush                 (fl0),
    .afull_thresh          (thr),
    .afull                 (afull0),
    .occ                   (occ0),
    .clk_en_req            (cer0),
    .pwrbus_ram_pd         (pwr)
  );

  nv_nvdla_sdp_ro_cfifo_gen #(.WIDTH(4), .DEPTH(4), .RD_REG(1)) u_dut1 (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .wr_pvld               (wv1),
    .wr_prdy               (wr_prdy1),
    .wr_pd                 (wd1),
    .rd_pvld               (rd_pvld1),
    .rd_prdy               (rr1),
    .rd_pd                 (rd_pd1),
    .flush                 (fl1),
    .afull_thresh          (thr),
    .afull                 (afull1),
    .occ                   (occ1),
    .clk_en_req            (cer1),
    .pwrbus_ram_pd         (pwr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int occ_m0, occ_m1, ram1;
    bit rv0;
    occ_m0 = q0.size();
    occ_m1 = q1.size();
    ram1   = occ_m1 - int'(vis1);
    rv0    = (occ_m0 != 0);
    chk("d0_wr_prdy", 32'(wr_prdy0), 32'((occ_m0 < 4) && !fl0));
    chk("d0_rd_pvld", 32'(rd_pvld0), 32'(rv0));
    if (rv0) chk("d0_rd_pd", 32'(rd_pd0), 32'(q0[0]));
    chk("d0_occ", 32'(occ0), 32'(occ_m0));
    chk("d0_afull", 32'(afull0), 32'(occ_m0 >= int'(thr)));
    chk("d0_clk_en_req", 32'(cer0), 32'(wv0 || rv0 || fl0 || (occ_m0 != 0)));
    chk("d1_wr_prdy", 32'(wr_prdy1), 32'((ram1 < 4) && !fl1));
    chk("d1_rd_pvld", 32'(rd_pvld1), 32'(vis1));
    if (vis1) chk("d1_rd_pd", 32'(rd_pd1), 32'(q1[0]));
    chk("d1_occ", 32'(occ1), 32'(occ_m1));
    chk("d1_afull", 32'(afull1), 32'(occ_m1 >= int'(thr)));
    chk("d1_clk_en_req", 32'(cer1), 32'(wv1 || vis1 || fl1 || (ram1 != 0)));
  endtask

  // Check current outputs, apply one clock edge, advance the models.
  task automatic step();
    bit p0, o0, p1, o1, ld1, f0, f1;
    int ram1;
    logic [3:0] d0, d1;
    #1;
    check_all();
    ram1 = q1.size() - int'(vis1);
    p0  = wv0 && (q0.size() < 4) && !fl0;
    o0  = (q0.size() != 0) && rr0;
    p1  = wv1 && (ram1 < 4) && !fl1;
    o1  = vis1 && rr1;
    ld1 = (ram1 != 0) && (!vis1 || o1);
    f0 = fl0; f1 = fl1; d0 = wd0; d1 = wd1;
    @(posedge clk);
    if (!rstn) begin
      q0.delete(); q1.delete(); vis1 = 1'b0;
    end else begin
      if (f0) q0.delete();
      else begin
        if (o0) void'(q0.pop_front());
        if (p0) q0.push_back(d0);
      end
      if (f1) begin
        q1.delete(); vis1 = 1'b0;
      end else begin
        if (o1) void'(q1.pop_front());
        if (p1) q1.push_back(d1);
        vis1 = ld1 ? 1'b1 : (o1 ? 1'b0 : vis1);
      end
    end
    #1;
  endtask

  task automatic idle();
    wv0 = 0; rr0 = 0; fl0 = 0; wv1 = 0; rr1 = 0; fl1 = 0;
  endtask

  initial begin
    pwr = 32'h0; thr = 3'd0; wd0 = '0; wd1 = '0;
    idle();
    #2;
    chk("d1_rd_pd_reset", 32'(rd_pd1), 32'h0);
    step();
    rstn = 1'b1;
    thr  = 3'd4;

    // Fill RD_REG=0 to full, hold a blocked push, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      wv0 = 1; wd0 = 4'(i); step();
    end
    wd0 = 4'hE; step();
    wv0 = 0; rr0 = 1;
    repeat (5) step();
    rr0 = 0;

    // Streaming push/pop with wrapping data.
    wv0 = 1; rr0 = 1;
    for (int i = 0; i < 20; i++) begin
      wd0 = 4'(i); step();
    end
    wv0 = 0; step(); rr0 = 0; step();

    // RD_REG=1 holds DEPTH+1 entries.
    wv1 = 1;
    for (int i = 0; i < 6; i++) begin
      wd1 = 4'(i); step();
    end
    wv1 = 0; rr1 = 1; step();
    rr1 = 0; step(); step();
    rr1 = 1; repeat (6) step();
    rr1 = 0;

    // Almost-full threshold around occupancy 3.
    thr = 3'd3;
    wv0 = 1; wd0 = 4'hA; step(); wd0 = 4'hB; step();
    wv0 = 0; step();
    wv0 = 1; wd0 = 4'hC; step();
    wv0 = 0; rr0 = 1; step();
    rr0 = 0; step();
    rr0 = 1; repeat (3) step(); rr0 = 0;

    // Flush with concurrent push and pop on both instances.
    wv0 = 1; wv1 = 1;
    for (int i = 0; i < 3; i++) begin
      wd0 = 4'(i + 7); wd1 = 4'(i + 9); step();
    end
    wv0 = 0; wv1 = 0; step();
    fl0 = 1; fl1 = 1; wv0 = 1; wv1 = 1; rr0 = 1; rr1 = 1; wd0 = 4'h5; wd1 = 4'h6;
    step();
    idle(); step(); step();

    // Asynchronous reset with two entries held and output valid.
    wv0 = 1; wv1 = 1; wd0 = 4'h3; wd1 = 4'h4; step();
    wd0 = 4'h8; wd1 = 4'h9; step();
    wv0 = 0; wv1 = 0; step();
    rstn = 1'b0;
    #1;
    chk("rst_d0_rd_pvld", 32'(rd_pvld0), 32'h0);
    chk("rst_d0_occ", 32'(occ0), 32'h0);
    chk("rst_d0_wr_prdy", 32'(wr_prdy0), 32'h1);
    chk("rst_d1_rd_pvld", 32'(rd_pvld1), 32'h0);
    chk("rst_d1_occ", 32'(occ1), 32'h0);
    chk("rst_d1_wr_prdy", 32'(wr_prdy1), 32'h1);
    chk("rst_d1_rd_pd", 32'(rd_pd1), 32'h0);
    q0.delete(); q1.delete(); vis1 = 1'b0;
    wv0 = 1; wv1 = 1; step();
    wv0 = 0; wv1 = 0; step();
    rstn = 1'b1;
    step();

    // Randomized traffic with occasional flushes and threshold changes.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) thr = 3'($urandom_range(0, 5));
      wv0 = ($urandom % 4) != 0; wd0 = 4'($urandom); rr0 = ($urandom % 3) != 0;
      fl0 = ($urandom % 40) == 0;
      wv1 = ($urandom % 4) != 0; wd1 = 4'($urandom); rr1 = ($urandom % 3) != 0;
      fl1 = ($urandom % 40) == 0;
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
